// File: rtl/reg_file_scoreboard_pkg.sv
// Shared definitions for the register-file scoreboard.
//   - Controller state encoding (IDLE / CLEAR).
//   - Default register width, address width and read-port count.
package reg_file_scoreboard_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 2;

  // CLEAR walks the array zeroing one register per cycle; busy is high only there.
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } rfState_t;

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port of the register-file scoreboard.
// Ports:
//   busy    in   clear sequence running; forces data and pending to 0
//   wrEn    in   same-cycle write enable (bypass source)
//   wrAddr  in   same-cycle write address
//   wrData  in   same-cycle write data
//   rdAddr  in   address read by this port
//   rfData  in   stored value at rdAddr
//   pendBit in   stored pending flag at rdAddr
//   rdData  out  read data
//   rdPend  out  pending flag seen by this port
module rf_read_port
  import reg_file_scoreboard_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              busy,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrData,
  input  logic [ADDR_W-1:0] rdAddr,
  input  logic [DATA_W-1:0] rfData,
  input  logic              pendBit,
  output logic [DATA_W-1:0] rdData,
  output logic              rdPend
);

  always_comb begin
    rdData = '0;
    rdPend = 1'b0;
    // Register 0 is hard-wired to zero and the whole array reads zero mid-clear.
    if (!busy && (rdAddr != '0)) begin
      if (wrEn && (wrAddr == rdAddr)) begin
        // A write landing this cycle resolves the hazard, so the reader sees
        // the new value and no pending flag.
        rdData = wrData;
      end else begin
        rdData = rfData;
        rdPend = pendBit;
      end
    end
  end

endmodule

// File: rtl/reg_file_scoreboard.sv
// Register file with per-register pending (scoreboard) bits, write bypass
// and a sequential clear engine.
// Ports:
//   clk      in   sole clock, rising edge
//   rst      in   synchronous active-high reset; starts a full clear
//   clr_req  in   one-cycle pulse requesting a full clear (ignored mid-clear)
//   busy     out  high while the clear sequence runs
//   wr_en    in   write enable (ignored while busy)
//   wr_addr  in   write address
//   wr_data  in   write data
//   rsv_en   in   reserve enable; marks rsv_addr pending (ignored while busy)
//   rsv_addr in   register to reserve
//   rd_addr  in   flattened read addresses, port i uses slice i
//   rd_data  out  flattened read data, combinational
//   rd_pend  out  per-port pending flag, combinational
module reg_file_scoreboard #(
  parameter int DATA_W = reg_file_scoreboard_pkg::DEF_DATA_W,
  parameter int ADDR_W = reg_file_scoreboard_pkg::DEF_ADDR_W,
  parameter int NUM_RD = reg_file_scoreboard_pkg::DEF_NUM_RD
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_req,
  output logic                     busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pend
);
  import reg_file_scoreboard_pkg::*;

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  rfState_t          stateReg;
  logic [ADDR_W-1:0] clrIdxReg;
  logic [DEPTH-1:0]  pendingReg;
  logic [DATA_W-1:0] rf [DEPTH];

  logic wrOk;
  logic rsvOk;

  assign busy  = (stateReg == CLEAR);
  // Address 0 is never stored or reserved.
  assign wrOk  = !busy && wr_en && (wr_addr != '0);
  assign rsvOk = !busy && rsv_en && (rsv_addr != '0);

  // Controller and pending bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg   <= CLEAR;
      clrIdxReg  <= ADDR_W'(1);
      pendingReg <= '0;
    end else begin
      case (stateReg)
        IDLE: begin
          if (clr_req) begin
            stateReg   <= CLEAR;
            clrIdxReg  <= ADDR_W'(1);
            pendingReg <= '0;
          end else begin
            if (wrOk)  pendingReg[wr_addr]  <= 1'b0;
            // Ordered after the write so a same-address reserve wins.
            if (rsvOk) pendingReg[rsv_addr] <= 1'b1;
          end
        end
        CLEAR: begin
          // clr_req is deliberately not looked at here: no restart mid-clear.
          clrIdxReg <= clrIdxReg + ADDR_W'(1);
          if (clrIdxReg == LAST_IDX) stateReg <= IDLE;
        end
        default: stateReg <= IDLE;
      endcase
    end
  end

  // Storage: no reset on data; the clear engine is the only way to zero it.
  // Register 0 is never written and is masked on read.
  always_ff @(posedge clk) begin
    if (busy) begin
      rf[clrIdxReg] <= '0;
    end else if (wrOk && !clr_req) begin
      rf[wr_addr] <= wr_data;
    end
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rdPort
    logic [ADDR_W-1:0] rdAddr;
    assign rdAddr = rd_addr[gi*ADDR_W +: ADDR_W];

    rf_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_rdPort (
      .busy    (busy),
      .wrEn    (wr_en),
      .wrAddr  (wr_addr),
      .wrData  (wr_data),
      .rdAddr  (rdAddr),
      .rfData  (rf[rdAddr]),
      .pendBit (pendingReg[rdAddr]),
      .rdData  (rd_data[gi*DATA_W +: DATA_W]),
      .rdPend  (rd_pend[gi])
    );
  end

endmodule

// File: tb/tb_reg_file_scoreboard.sv
module tb_reg_file_scoreboard;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;
  localparam int DEPTH  = 32;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic                     clr_req = 1'b0;
  logic                     busy;
  logic                     wr_en = 1'b0;
  logic [ADDR_W-1:0]        wr_addr = '0;
  logic [DATA_W-1:0]        wr_data = '0;
  logic                     rsv_en = 1'b0;
  logic [ADDR_W-1:0]        rsv_addr = '0;
  logic [NUM_RD*ADDR_W-1:0] rd_addr = '0;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_pend;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  reg_file_scoreboard #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .busy     (busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_pend  (rd_pend)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] rdD(input int p);
    return rd_data[p*DATA_W +: DATA_W];
  endfunction

  task automatic setRd(input int p, input int a);
    rd_addr[p*ADDR_W +: ADDR_W] = ADDR_W'(a);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  // Architectural view: a value array, a pending set and a count of clear
  // cycles remaining. Contents read as zero for the whole clear, so the model
  // simply wipes everything when a clear starts.
  logic [DATA_W-1:0] mMem [DEPTH];
  bit                mPend [DEPTH];
  int                mClearLeft = 0;
  bit                checkEn = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      mClearLeft = DEPTH - 1;
      for (int i = 0; i < DEPTH; i++) begin mMem[i] = '0; mPend[i] = 1'b0; end
      checkEn = 1'b1;
    end else if (mClearLeft > 0) begin
      mClearLeft = mClearLeft - 1;
    end else if (clr_req) begin
      mClearLeft = DEPTH - 1;
      for (int i = 0; i < DEPTH; i++) begin mMem[i] = '0; mPend[i] = 1'b0; end
    end else begin
      if (wr_en && wr_addr != 0) begin
        mMem[wr_addr]  = wr_data;
        mPend[wr_addr] = 1'b0;
      end
      if (rsv_en && rsv_addr != 0) mPend[rsv_addr] = 1'b1;
    end
  end

  // Compare process: every cycle once the model has been reset.
  always @(negedge clk) begin
    logic              expBusy;
    logic [ADDR_W-1:0] a;
    logic              hit;
    logic [DATA_W-1:0] expD;
    logic              expP;
    if (checkEn) begin
      expBusy = (mClearLeft > 0);
      chk("model_busy", {31'b0, busy}, {31'b0, expBusy});
      for (int p = 0; p < NUM_RD; p++) begin
        a    = rd_addr[p*ADDR_W +: ADDR_W];
        hit  = wr_en && (wr_addr == a);
        expD = (expBusy || a == 0) ? '0 : (hit ? wr_data : mMem[a]);
        expP = (expBusy || a == 0 || hit) ? 1'b0 : mPend[a];
        chk($sformatf("model_rd_data%0d", p), rdD(p), expD);
        chk($sformatf("model_rd_pend%0d", p), {31'b0, rd_pend[p]}, {31'b0, expP});
      end
    end
  end

  function automatic logic [ADDR_W-1:0] randAddr();
    if ($urandom_range(0, 4) == 0) return '0;
    if ($urandom_range(0, 1) == 1) return ADDR_W'($urandom_range(1, 7));
    return ADDR_W'($urandom_range(0, DEPTH - 1));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // Reset then count busy cycles.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n = 0;
    while (busy && n < 100) begin n++; tick(); end
    $display("txn reset: busy lasted %0d cycles", n);
    chk("rst_busy_len", n, 31);

    // Every address reads 0 and not pending after reset.
    for (int a = 0; a < DEPTH; a += 2) begin
      setRd(0, a); setRd(1, a + 1);
      @(negedge clk);
      chk("rst_zero_d0", rdD(0), 32'h0);
      chk("rst_zero_d1", rdD(1), 32'h0);
      chk("rst_zero_pend", {30'b0, rd_pend}, 32'h0);
      tick();
    end
    $display("txn reset sweep done");

    // Write bypass on r5.
    wr_en = 1'b1; wr_addr = 5; wr_data = 32'hDEADBEEF; setRd(0, 5); setRd(1, 5);
    @(negedge clk);
    $display("txn write r5=deadbeef with same-cycle read");
    chk("bypass_r5", rdD(0), 32'hDEADBEEF);
    chk("bypass_r5_p1", rdD(1), 32'hDEADBEEF);
    tick();
    wr_en = 1'b0;
    @(negedge clk);
    chk("stored_r5", rdD(0), 32'hDEADBEEF);
    tick();

    // Reserve r7, then resolve with a write.
    rsv_en = 1'b1; rsv_addr = 7;
    $display("txn reserve r7");
    tick();
    rsv_en = 1'b0; setRd(0, 7);
    @(negedge clk);
    chk("r7_pend_set", {31'b0, rd_pend[0]}, 32'd1);
    tick();
    wr_en = 1'b1; wr_addr = 7; wr_data = 32'h12;
    $display("txn write r7=12");
    @(negedge clk);
    chk("r7_pend_bypass", {31'b0, rd_pend[0]}, 32'd0);
    tick();
    wr_en = 1'b0;
    @(negedge clk);
    chk("r7_pend_clear", {31'b0, rd_pend[0]}, 32'd0);
    chk("r7_data", rdD(0), 32'h12);
    tick();

    // Same-cycle write and reserve on r9: reserve wins.
    wr_en = 1'b1; wr_addr = 9; wr_data = 32'h55; rsv_en = 1'b1; rsv_addr = 9;
    $display("txn write+reserve r9=55");
    tick();
    wr_en = 1'b0; rsv_en = 1'b0; setRd(0, 9);
    @(negedge clk);
    chk("r9_data", rdD(0), 32'h55);
    chk("r9_pend", {31'b0, rd_pend[0]}, 32'd1);
    tick();

    // r0 is immutable.
    wr_en = 1'b1; wr_addr = 0; wr_data = 32'hFFFFFFFF; rsv_en = 1'b1; rsv_addr = 0;
    setRd(0, 0); setRd(1, 0);
    $display("txn write+reserve r0");
    @(negedge clk);
    chk("r0_same_d0", rdD(0), 32'h0);
    chk("r0_same_d1", rdD(1), 32'h0);
    tick();
    wr_en = 1'b0; rsv_en = 1'b0;
    @(negedge clk);
    chk("r0_d0", rdD(0), 32'h0);
    chk("r0_d1", rdD(1), 32'h0);
    chk("r0_pend", {30'b0, rd_pend}, 32'h0);
    tick();

    // Fill r1..r31, then clear with a second request and writes mid-clear.
    for (int a = 1; a < DEPTH; a++) begin
      wr_en = 1'b1; wr_addr = ADDR_W'(a); wr_data = 32'h01010101 * a;
      tick();
    end
    wr_en = 1'b0; setRd(0, 31); setRd(1, 12);
    @(negedge clk);
    $display("txn filled r1..r31");
    chk("fill_r31", rdD(0), 32'h1F1F1F1F);
    chk("fill_r12", rdD(1), 32'h0C0C0C0C);
    tick();
    clr_req = 1'b1;
    $display("txn clr_req");
    tick();
    clr_req = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      wr_en = 1'b1; wr_addr = ADDR_W'($urandom_range(1, DEPTH - 1)); wr_data = $urandom | 32'h1;
      clr_req = (n == 10);
      tick();
    end
    wr_en = 1'b0; clr_req = 1'b0;
    $display("txn clear: busy lasted %0d cycles", n);
    chk("clr_busy_len", n, 31);
    for (int a = 0; a < DEPTH; a += 2) begin
      setRd(0, a); setRd(1, a + 1);
      @(negedge clk);
      chk("clr_zero_d0", rdD(0), 32'h0);
      chk("clr_zero_d1", rdD(1), 32'h0);
      tick();
    end

    // Randomized traffic checked by the model.
    for (int i = 0; i < 800; i++) begin
      rst      = ($urandom_range(0, 399) == 0);
      clr_req  = ($urandom_range(0, 149) == 0);
      wr_en    = $urandom_range(0, 1);
      wr_addr  = randAddr();
      wr_data  = $urandom;
      rsv_en   = ($urandom_range(0, 2) == 0);
      rsv_addr = ($urandom_range(0, 3) == 0) ? wr_addr : randAddr();
      setRd(0, ($urandom_range(0, 3) == 0) ? int'(wr_addr) : int'(randAddr()));
      setRd(1, ($urandom_range(0, 3) == 0) ? int'(rd_addr[ADDR_W-1:0]) : int'(randAddr()));
      $display("txn rand %0d: rst=%0b clr=%0b wr=%0b@%0d=%h rsv=%0b@%0d rd=%0d,%0d",
               i, rst, clr_req, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
               rd_addr[ADDR_W-1:0], rd_addr[2*ADDR_W-1:ADDR_W]);
      tick();
    end
    rst = 1'b0; clr_req = 1'b0; wr_en = 1'b0; rsv_en = 1'b0;
    @(negedge clk);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/reg_file_scoreboard.md
REG_FILE_SCOREBOARD -- requirements
Module: reg_file_scoreboard

Interface
REQ-001 Parameter DATA_W, default 32, register width in bits.
REQ-002 Parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W registers.
REQ-003 Parameter NUM_RD, default 2, number of read ports (1..4).
REQ-004 Port clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 Port rst  input  1  reset, synchronous, active-high.
REQ-006 Port clr_req  input  1  request a full array clear; one-cycle pulse.
REQ-007 Port busy  output  1  high while the clear sequence runs.
REQ-008 Port wr_en  input  1  write enable.
REQ-009 Port wr_addr  input  ADDR_W  write address.
REQ-010 Port wr_data  input  DATA_W  write data.
REQ-011 Port rsv_en  input  1  reserve enable; marks a register pending.
REQ-012 Port rsv_addr  input  ADDR_W  register to reserve.
REQ-013 Port rd_addr  input  NUM_RD*ADDR_W  flattened read addresses; port i uses slice i.
REQ-014 Port rd_data  output  NUM_RD*DATA_W  flattened read data; combinational.
REQ-015 Port rd_pend  output  NUM_RD  per-port pending flag; combinational.

Function
REQ-016 Register 0 SHALL always read 0 and never be pending; writes and reserves to address 0 SHALL be ignored.
REQ-017 FSM states SHALL be IDLE and CLEAR; busy SHALL be 1 exactly in CLEAR.
REQ-018 In CLEAR, a clear index starting at 1 SHALL zero one register per cycle and increment; after zeroing DEPTH-1 the FSM SHALL enter IDLE on the next edge.
REQ-019 A clear SHALL last DEPTH-1 cycles (31 at default).
REQ-020 clr_req in IDLE SHALL enter CLEAR on the next edge and clear all pending bits; clr_req during CLEAR SHALL be ignored and SHALL NOT restart the sequence.
REQ-021 With busy=0 and wr_en=1, rf[wr_addr] SHALL take wr_data and pending[wr_addr] SHALL clear on the next edge.
REQ-022 With busy=0 and rsv_en=1, pending[rsv_addr] SHALL set on the next edge.
REQ-023 When a write and a reserve target the same address in the same cycle, the data SHALL be written and pending SHALL end at 1 (reserve wins).
REQ-024 wr_en and rsv_en SHALL be ignored while busy=1.
REQ-025 rd_data[i] SHALL be 0 if rd_addr[i]=0 or busy=1; otherwise wr_data if wr_en=1 and wr_addr=rd_addr[i] (write bypass); otherwise rf[rd_addr[i]].
REQ-026 rd_pend[i] SHALL be 0 if busy=1 or rd_addr[i]=0 or a same-cycle write hits rd_addr[i]; otherwise pending[rd_addr[i]].
REQ-027 All read ports SHALL be independent; identical addresses on several ports SHALL return identical results.

Reset
REQ-028 rst SHALL put the FSM in CLEAR, set the clear index to 1 and clear all pending bits; busy SHALL read 1 in the first cycle after rst.
REQ-029 rst asserted mid-clear SHALL restart the clear at index 1.
REQ-030 rst SHALL take priority over clr_req, wr_en and rsv_en.

Structure
REQ-031 FSM state encoding and the default DATA_W and ADDR_W values SHALL live in a shared package used by the datapath blocks.
REQ-032 Read-port mux and bypass logic SHALL be one sub-module, rf_read_port, instantiated NUM_RD times by a generate loop.
REQ-033 The storage array SHALL be a single synchronous-write array with no reset on its data bits.

Verification
REQ-034 Pulse rst, then hold idle -> busy=1 for exactly 31 cycles; every address then reads 0 with rd_pend=0.
REQ-035 Write 0xDEADBEEF to r5 while reading r5 on port 0 -> rd_data=0xDEADBEEF in the same cycle, and again on the following cycle.
REQ-036 Reserve r7; next cycle read r7 -> rd_pend=1; write r7=0x12 -> rd_pend=0 in that cycle; next cycle rd_pend=0 and rd_data=0x12.
REQ-037 Same-cycle write r9=0x55 and reserve r9 -> next cycle rd_data=0x55 and rd_pend=1.
REQ-038 Write r0=0xFFFFFFFF and reserve r0 -> r0 reads 0 with rd_pend=0 on every port.
REQ-039 clr_req after filling r1..r31 with nonzero values; second clr_req at clear cycle 10; wr_en asserted during the clear -> busy lasts exactly 31 cycles from the first request; all registers read 0 afterward; writes made during the clear are not stored.
